// File: rtl/serial_alu_sequencer_if.sv
// serial_alu_sequencer_if
//   Request/result bundle between the register/control logic (master) and the
//   bit-serial ALU sequencer (slave).
//   start            : request, sampled by the sequencer only while idle
//   a, b             : WIDTH-bit operands, captured on the accepting edge
//   op               : 3-bit opcode (AND NOR OR XOR NAND ADD SUB SLT)
//   busy             : sequencer is running or committing
//   done             : one-cycle completion pulse
//   result           : committed result, held until the next commit
//   carryout/overflow/zero : committed flags, held with result
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, op,
    input  busy, done, result, carryout, overflow, zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, carryout, overflow, zero
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// serial_alu_sequencer
//   Runs a WIDTH-bit ALU operation through one external 1-bit ALU slice, LSB
//   first, one bit per clock, then commits result and flags with a one-cycle
//   done pulse. Latency is WIDTH+1 cycles from the accepting edge to done.
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : start/a/b/op request, busy/done/result/flags response
//   slice_a_o/_b_o    : current operand bits to the slice
//   slice_carryin_o   : carry into the slice (carry flop)
//   slice_negate_o    : invert b inside the slice (SUB/SLT)
//   slice_sel_o       : slice function select
//   slice_out_i       : slice result bit
//   slice_carryout_i  : slice carry out
//
// state  | meaning
// IDLE   | waiting for start; slice inputs held at 0
// RUN    | one operand bit per cycle through the slice
// DONE   | result committed; done high for this cycle only
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_alu_sequencer_if.slave  bus,
  output logic                   slice_a_o,
  output logic                   slice_b_o,
  output logic                   slice_carryin_o,
  output logic                   slice_negate_o,
  output logic [2:0]             slice_sel_o,
  input  logic                   slice_out_i,
  input  logic                   slice_carryout_i
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic             last_bit;
  logic             is_sub_q;
  logic [WIDTH-1:0] res_shift;
  logic             ov_arith;

  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign is_sub_q  = op_q[2] & op_q[1];
  assign res_shift = {slice_out_i, res_sh_q[WIDTH-1:1]};
  // On the final edge carry_q still holds the carry into the MSB.
  assign ov_arith  = carry_q ^ slice_carryout_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status and slice drive
  always_comb begin
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    slice_a_o       = 1'b0;
    slice_b_o       = 1'b0;
    slice_carryin_o = 1'b0;
    slice_negate_o  = 1'b0;
    slice_sel_o     = 3'b000;
    if (state_q == S_RUN) begin
      slice_a_o       = a_sh_q[0];
      slice_b_o       = b_sh_q[0];
      slice_carryin_o = carry_q;
      slice_negate_o  = is_sub_q;
      // SUB and SLT run through the adder with b negated.
      slice_sel_o     = is_sub_q ? OP_ADD : op_q;
    end
  end

  assign bus.result   = result_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

  // Datapath next-state
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_sh_d   = res_sh_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          carry_d = bus.op[2] & bus.op[1];
        end
      end
      S_RUN: begin
        res_sh_d = res_shift;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = slice_carryout_i;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_d   = res_shift;
              carryout_d = slice_carryout_i;
              overflow_d = ov_arith;
            end
            OP_SLT: begin
              // Signed less-than: sign of the difference corrected by overflow.
              result_d   = {{(WIDTH-1){1'b0}}, slice_out_i ^ ov_arith};
              carryout_d = 1'b0;
              overflow_d = 1'b0;
            end
            default: begin
              result_d   = res_shift;
              carryout_d = 1'b0;
              overflow_d = 1'b0;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_sh_q   <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_sh_q   <= res_sh_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb_serial_alu_sequencer
//   Directed bench for serial_alu_sequencer at WIDTH=8 with a behavioural
//   1-bit ALU slice closing the loop.
module tb_serial_alu_sequencer;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       slice_a, slice_b, slice_carryin, slice_negate;
  logic [2:0] slice_sel;
  logic       slice_out, slice_carryout;

  int n_checks;
  int n_pass;

  serial_alu_sequencer_if #(.WIDTH(W)) bus ();

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .slice_a_o        (slice_a),
    .slice_b_o        (slice_b),
    .slice_carryin_o  (slice_carryin),
    .slice_negate_o   (slice_negate),
    .slice_sel_o      (slice_sel),
    .slice_out_i      (slice_out),
    .slice_carryout_i (slice_carryout)
  );

  // Behavioural bit slice
  logic sb, ssum;
  always_comb begin
    sb             = slice_negate ? ~slice_b : slice_b;
    ssum           = slice_a ^ sb ^ slice_carryin;
    slice_carryout = (slice_a & sb) | (slice_a & slice_carryin) | (sb & slice_carryin);
    case (slice_sel)
      3'b000:  slice_out = slice_a & sb;
      3'b001:  slice_out = ~(slice_a | sb);
      3'b010:  slice_out = slice_a | sb;
      3'b011:  slice_out = slice_a ^ sb;
      3'b100:  slice_out = ~(slice_a & sb);
      3'b101:  slice_out = ssum;
      default: slice_out = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #200 clk = ~clk;

  // Issue one op; lat = negedges after the accepting edge until done is seen
  // (0 on timeout). First-RUN-cycle slice controls are returned too.
  task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [2:0] sel0, output logic neg0,
                        output logic cin0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.op = o;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 8'h5A; bus.b = 8'h3C; bus.op = 3'b011;
    lat = 0; sel0 = 3'b000; neg0 = 1'b0; cin0 = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        sel0 = slice_sel; neg0 = slice_negate; cin0 = slice_carryin;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 3'b101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b exp 0", bus.done); else n_pass++;
    n_checks++; if (bus.result !== 8'h00) $display("FAIL reset_result: got %h exp 00", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b000)
      $display("FAIL reset_flags: got %b exp 000", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
    n_checks++; if ({slice_a, slice_b, slice_carryin, slice_negate, slice_sel} !== 7'b0)
      $display("FAIL reset_slice: got %b exp 0000000", {slice_a, slice_b, slice_carryin, slice_negate, slice_sel}); else n_pass++;
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", bus.busy); else n_pass++;
  endtask

  task automatic test_add();
    int lat; logic [2:0] s0; logic n0, c0;
    run_op(3'b101, 8'hFF, 8'h01, lat, s0, n0, c0);
    n_checks++; if (lat !== 9) $display("FAIL add_latency: got %0d exp 9", lat); else n_pass++;
    n_checks++; if ({s0, n0, c0} !== 5'b10100) $display("FAIL add_slice_ctl: got %b exp 10100", {s0, n0, c0}); else n_pass++;
    n_checks++; if (bus.result !== 8'h00) $display("FAIL add_result: got %h exp 00", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b101)
      $display("FAIL add_flags: got %b exp 101", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.done, bus.busy} !== 2'b00) $display("FAIL add_after_done: got %b exp 00", {bus.done, bus.busy}); else n_pass++;
    n_checks++; if (bus.result !== 8'h00 || bus.carryout !== 1'b1)
      $display("FAIL add_hold: got %h/%b exp 00/1", bus.result, bus.carryout); else n_pass++;
  endtask

  task automatic test_sub();
    int lat; logic [2:0] s0; logic n0, c0;
    run_op(3'b110, 8'h80, 8'h01, lat, s0, n0, c0);
    n_checks++; if (lat !== 9) $display("FAIL sub1_latency: got %0d exp 9", lat); else n_pass++;
    n_checks++; if ({s0, n0, c0} !== 5'b10111) $display("FAIL sub_slice_ctl: got %b exp 10111", {s0, n0, c0}); else n_pass++;
    n_checks++; if (bus.result !== 8'h7F) $display("FAIL sub1_result: got %h exp 7f", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b110)
      $display("FAIL sub1_flags: got %b exp 110", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
    run_op(3'b110, 8'h05, 8'h05, lat, s0, n0, c0);
    n_checks++; if (bus.result !== 8'h00) $display("FAIL sub2_result: got %h exp 00", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b101)
      $display("FAIL sub2_flags: got %b exp 101", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
  endtask

  task automatic test_slt();
    int lat; logic [2:0] s0; logic n0, c0;
    run_op(3'b111, 8'hFE, 8'h01, lat, s0, n0, c0);
    n_checks++; if ({s0, n0, c0} !== 5'b10111) $display("FAIL slt_slice_ctl: got %b exp 10111", {s0, n0, c0}); else n_pass++;
    n_checks++; if (bus.result !== 8'h01) $display("FAIL slt1_result: got %h exp 01", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b000)
      $display("FAIL slt1_flags: got %b exp 000", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
    run_op(3'b111, 8'h7F, 8'h80, lat, s0, n0, c0);
    n_checks++; if (bus.result !== 8'h00) $display("FAIL slt2_result: got %h exp 00", bus.result); else n_pass++;
    n_checks++; if ({bus.carryout, bus.overflow, bus.zero} !== 3'b001)
      $display("FAIL slt2_flags: got %b exp 001", {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
  endtask

  task automatic test_logic();
    int lat; logic [2:0] s0; logic n0, c0;
    logic [2:0] ops [5];
    logic [7:0] exps [5];
    ops  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    exps = '{8'h81, 8'h18, 8'hE7, 8'h66, 8'h7E};
    for (int k = 0; k < 5; k++) begin
      run_op(ops[k], 8'hC3, 8'hA5, lat, s0, n0, c0);
      n_checks++; if (bus.result !== exps[k] || lat !== 9)
        $display("FAIL logic_op%0d_result: got %h lat %0d exp %h lat 9", k, bus.result, lat, exps[k]); else n_pass++;
      n_checks++; if ({s0, n0, bus.carryout, bus.overflow} !== {ops[k], 3'b000})
        $display("FAIL logic_op%0d_ctl: got %b exp %b", k, {s0, n0, bus.carryout, bus.overflow}, {ops[k], 3'b000}); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    int lat; int extra;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h0A; bus.b = 8'h14; bus.op = 3'b101;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.op = 3'b000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    n_checks++; if (lat !== 9) $display("FAIL ignore_latency: got %0d exp 9", lat); else n_pass++;
    n_checks++; if (bus.result !== 8'h1E) $display("FAIL ignore_result: got %h exp 1e", bus.result); else n_pass++;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL ignore_not_queued: got %0d busy cycles exp 0", extra); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1, d2, d3;
    logic [7:0] r2;
    d1 = 0; d2 = 0; d3 = 0; r2 = 8'h00;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h03; bus.b = 8'h04; bus.op = 3'b101;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 == 0) d1 = i;
        else if (d2 == 0) begin d2 = i; r2 = bus.result; end
        else if (d3 == 0) d3 = i;
      end
    end
    bus.start = 1'b0;
    n_checks++; if (d1 !== 9) $display("FAIL b2b_first_done: got %0d exp 9", d1); else n_pass++;
    n_checks++; if (d2 - d1 !== 10 || d3 - d2 !== 10)
      $display("FAIL b2b_spacing: got %0d,%0d exp 10,10", d2 - d1, d3 - d2); else n_pass++;
    n_checks++; if (r2 !== 8'h07) $display("FAIL b2b_result: got %h exp 07", r2); else n_pass++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int lat; int seen; logic [2:0] s0; logic n0, c0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.op = 3'b101;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL rst_run_busy: got %b exp 00", {bus.busy, bus.done}); else n_pass++;
    n_checks++; if (bus.result !== 8'h00 || {bus.carryout, bus.overflow, bus.zero} !== 3'b000)
      $display("FAIL rst_run_clear: got %h/%b exp 00/000", bus.result, {bus.carryout, bus.overflow, bus.zero}); else n_pass++;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rst_run_no_done: got %0d cycles exp 0", seen); else n_pass++;
    run_op(3'b101, 8'h12, 8'h34, lat, s0, n0, c0);
    n_checks++; if (bus.result !== 8'h46 || lat !== 9)
      $display("FAIL rst_run_after: got %h lat %0d exp 46 lat 9", bus.result, lat); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = 3'b000;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_alu_sequencer.md
# serial_alu_sequencer

Sequences a single external `bitSliceALU` to run a full WIDTH-bit ALU operation bit-serially, LSB first, one bit per clock. It latches operands and opcode on `start` and drives the slice's a/b/carryin/sel/negate each cycle. It captures the slice's sum and carry into a shift register and carry flop, then commits result and flags with a one-cycle `done`. It sits between the register/control logic and the slice, trading WIDTH+1 cycles of latency for one slice of area.

## Interface
- `WIDTH`, 32: operand/result width in bits; minimum 2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`, `b`  in  WIDTH  operands; sampled on the accepting edge only.
- `op`  in  3  000 AND, 001 NOR, 010 OR, 011 XOR, 100 NAND, 101 ADD, 110 SUB, 111 SLT (signed).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  committed result; held until next commit.
- `carryout`, `overflow`, `zero`  out  1  committed flags; held with `result`.
- `slice_a`, `slice_b`, `slice_carryin`, `slice_negate`  out  1  drive to slice.
- `slice_sel`  out  3  slice select.
- `slice_out`, `slice_carryout`  in  1  from slice.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, and clears all outputs, shift registers, bit counter and carry flop to 0.
- IDLE with `start`=1:
  - load `a`/`b` into shift registers and `op` into the op register;
  - set the counter to 0;
  - set carry flop = 1 for SUB/SLT, else 0;
  - go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, combinational drive:
  - `slice_a`/`slice_b` = shift-register bit 0.
  - `slice_carryin` = carry flop.
  - `slice_sel` = op for codes 000–101; `slice_sel` = 101 for SUB/SLT.
  - `slice_negate` = 1 only for SUB/SLT.
- RUN, each edge:
  - shift `slice_out` into the result shift register at the MSB end, and shift the operands right;
  - carry flop <= `slice_carryout`;
  - increment the counter.
  - On the edge where the counter = WIDTH-1, go to DONE and record carry-into-MSB (the pre-edge carry flop).
- Commit on entry to DONE:
  - AND/NOR/OR/XOR/NAND: `result` = shifted bits; `carryout`=0; `overflow`=0.
  - ADD/SUB: `result` = shifted bits; `carryout` = final slice carry; `overflow` = carry-into-MSB XOR final carry.
  - SLT: `result` = {WIDTH-1 zeros, MSB-of-difference XOR overflow}; `carryout`=0; `overflow`=0.
  - `zero` = (committed `result` == 0).
- DONE: `done`=1 for this cycle only; next edge goes to IDLE unconditionally.
- In IDLE and DONE, all slice drive outputs = 0.
- `start` while `busy`=1 is ignored and not queued. `start` held high re-triggers on the first IDLE edge after DONE.
- Operands that change after acceptance have no effect.

## Timing
- Accept edge E0. Bit i is captured at edge E(i+1). Commit and DONE entry at E(WIDTH). `done` is high in the cycle after E(WIDTH). IDLE is re-entered at E(WIDTH+1).
- Latency is WIDTH+1 cycles from the accepting edge to `done`. Throughput is one op per WIDTH+2 cycles with `start` held.
- `busy` rises after E0 and falls after E(WIDTH+1).
- The clock period must exceed the slice's worst gate path, through the negate XOR, adder and mux. Benches use a period ≥ 400 time units.
- Slice inputs change only after clock edges. Capture uses values settled before the edge.
- Reset low at any edge, including mid-RUN or in DONE: IDLE on the next cycle, no `done` pulse, `result` and flags cleared to 0.

## Test plan
- WIDTH=8, ADD a=8'hFF b=8'h01 -> `done` exactly 9 cycles after accept; `result`=8'h00, `carryout`=1, `overflow`=0, `zero`=1.
- SUB a=8'h80 b=8'h01 -> `result`=8'h7F, `carryout`=1, `overflow`=1, `zero`=0. Then SUB a=8'h05 b=8'h05 -> `result`=8'h00, `zero`=1.
- SLT a=8'hFE b=8'h01 -> `result`=8'h01. SLT a=8'h7F b=8'h80 -> `result`=8'h00. Both with `carryout`=0 and `overflow`=0.
- Logic ops with a=8'hC3 b=8'hA5:
  - AND -> 8'h81
  - NOR -> 8'h18
  - OR -> 8'hE7
  - XOR -> 8'h66
  - NAND -> 8'h7E
  - all with `carryout`=0.
- Second `start` pulse with new operands at cycle 3 of RUN -> ignored; first result unchanged. `start` held high -> back-to-back ops every 10 cycles.
- `rst_n`=0 at cycle 4 of RUN -> IDLE next cycle, `busy`=0, `result`=0, no `done`. A new op afterwards computes correctly.
